// File: rtl/zip_alu_pkg.sv
// Shared opcode map, flag bit positions and FSM state type for the Zip execute ALU.
package zip_alu_pkg;

    localparam logic [3:0] OP_SUB    = 4'h0;
    localparam logic [3:0] OP_AND    = 4'h1;
    localparam logic [3:0] OP_ADD    = 4'h2;
    localparam logic [3:0] OP_OR     = 4'h3;
    localparam logic [3:0] OP_XOR    = 4'h4;
    localparam logic [3:0] OP_LSR    = 4'h5;
    localparam logic [3:0] OP_LSL    = 4'h6;
    localparam logic [3:0] OP_ASR    = 4'h7;
    localparam logic [3:0] OP_MPY    = 4'h8;
    localparam logic [3:0] OP_LODILO = 4'h9;
    localparam logic [3:0] OP_MPYHU  = 4'hA;
    localparam logic [3:0] OP_MPYHS  = 4'hB;
    localparam logic [3:0] OP_BREV   = 4'hC;
    localparam logic [3:0] OP_POPC   = 4'hD;
    localparam logic [3:0] OP_ROL    = 4'hE;
    localparam logic [3:0] OP_MOV    = 4'hF;

    localparam int F_Z = 0;
    localparam int F_C = 1;
    localparam int F_N = 2;
    localparam int F_V = 3;

    typedef enum logic {IDLE = 1'b0, MPY = 1'b1} state_t;

endpackage

// File: rtl/zip_alu_mpy.sv
// DWxDW -> 2DW multiplier registered over MPY_STAGES stages, with a flushable valid pipe.
module zip_alu_mpy #(
    parameter int DW         = 32,
    parameter int MPY_STAGES = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic            i_clear,
    input  logic            i_signed,
    input  logic [DW-1:0]   i_a,
    input  logic [DW-1:0]   i_b,
    output logic [2*DW-1:0] o_prod,
    output logic            o_valid
);

    logic signed [2*DW-1:0] w_a_ext;
    logic signed [2*DW-1:0] w_b_ext;
    logic signed [2*DW-1:0] r_prod_p [MPY_STAGES];
    logic [MPY_STAGES-1:0]  r_vld_p;

    // Extending to 2DW first makes the truncated product exact for both signednesses
    assign w_a_ext = {{DW{i_signed & i_a[DW-1]}}, i_a};
    assign w_b_ext = {{DW{i_signed & i_b[DW-1]}}, i_b};

    // Stage p0 captures the product on the accepting edge; later stages just delay it
    always_ff @(posedge i_clk) begin
        if (i_start)
            r_prod_p[0] <= w_a_ext * w_b_ext;
        for (int k = 1; k < MPY_STAGES; k++)
            r_prod_p[k] <= r_prod_p[k-1];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld_p <= '0;
        end else if (i_clear) begin
            r_vld_p <= '0;
        end else begin
            r_vld_p[0] <= i_start;
            for (int k = 1; k < MPY_STAGES; k++)
                r_vld_p[k] <= r_vld_p[k-1];
        end
    end

    assign o_prod  = r_prod_p[MPY_STAGES-1];
    assign o_valid = r_vld_p[MPY_STAGES-1];

endmodule

// File: rtl/zip_alu_ex.sv
// Zip CPU execute-stage ALU with pipelined multiplier and flush.
// Define ZIP_ALU_LODI_EN to turn op 8 into single-cycle LODIHI instead of MPY.
module zip_alu_ex
    import zip_alu_pkg::*;
#(
    parameter int DW         = 32,
    parameter int MPY_STAGES = 2
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_ce,
    input  logic          i_valid,
    input  logic          i_clear,
    input  logic [3:0]    i_op,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic [DW-1:0] o_c,
    output logic [3:0]    o_f,
    output logic          o_valid,
    output logic          o_busy,
    output logic          o_illegal
);

    localparam int            CW      = $clog2(DW) + 2;
    localparam int            RW      = $clog2(DW);
    localparam logic [DW-1:0] DW_L    = DW'(DW);
    localparam bit            HAS_MPY = (MPY_STAGES > 0);

    state_t            r_state, w_next;
    logic [2:0]        r_cnt;
    logic              r_mpy_hi;
    logic              w_accept, w_start_mpy, w_done, w_busy;
    logic              w_mpy_op, w_ill, w_c, w_v;
    logic [DW-1:0]     w_res, w_mpy_res;
    logic [3:0]        w_f, w_mf;
    logic [CW-1:0]     w_cnt;
    logic [2*DW-1:0]   w_prod;
    logic              w_mpy_vld;

    // Counts beyond DW behave identically, so clamp to DW+1 to keep shifters narrow
    function automatic logic [CW-1:0] f_sat_cnt(input logic [DW-1:0] b);
        if (b > DW_L)
            return CW'(DW + 1);
        return b[CW-1:0];
    endfunction

    function automatic logic [DW:0] f_lsr(input logic [DW-1:0] a, input logic [CW-1:0] n);
        logic [DW:0] t;
        t = {a, 1'b0} >> n;
        return {t[0], t[DW:1]};
    endfunction

    function automatic logic [DW:0] f_lsl(input logic [DW-1:0] a, input logic [CW-1:0] n);
        logic [DW:0] t;
        t = {1'b0, a} << n;
        return t;
    endfunction

    function automatic logic [DW:0] f_asr(input logic [DW-1:0] a, input logic [CW-1:0] n);
        logic signed [DW:0] t;
        t = $signed({a, 1'b0}) >>> n;
        return {t[0], t[DW:1]};
    endfunction

    function automatic logic [DW-1:0] f_rol(input logic [DW-1:0] a, input logic [RW-1:0] s);
        logic [2*DW-1:0] t;
        t = {a, a} << s;
        return t[2*DW-1:DW];
    endfunction

    function automatic logic [DW-1:0] f_brev(input logic [DW-1:0] b);
        logic [DW-1:0] r;
        for (int k = 0; k < DW; k++)
            r[k] = b[DW-1-k];
        return r;
    endfunction

    function automatic logic [DW-1:0] f_popc(input logic [DW-1:0] b);
        logic [DW-1:0] n;
        n = '0;
        for (int k = 0; k < DW; k++)
            n = n + DW'(b[k]);
        return n;
    endfunction

    assign w_cnt       = f_sat_cnt(i_b);
    assign w_accept    = i_ce && i_valid && !w_busy && !i_clear;
    assign w_start_mpy = w_accept && w_mpy_op && HAS_MPY;

    always_comb begin
        w_res    = '0;
        w_c      = 1'b0;
        w_v      = 1'b0;
        w_mpy_op = 1'b0;
        w_ill    = 1'b0;
        case (i_op)
            OP_SUB: begin
                {w_c, w_res} = {1'b0, i_a} - {1'b0, i_b};
                w_v = (i_a[DW-1] != i_b[DW-1]) && (w_res[DW-1] != i_a[DW-1]);
            end
            OP_AND: w_res = i_a & i_b;
            OP_ADD: begin
                {w_c, w_res} = {1'b0, i_a} + {1'b0, i_b};
                w_v = (i_a[DW-1] == i_b[DW-1]) && (w_res[DW-1] != i_a[DW-1]);
            end
            OP_OR:  w_res = i_a | i_b;
            OP_XOR: w_res = i_a ^ i_b;
            OP_LSR: begin
                {w_c, w_res} = f_lsr(i_a, w_cnt);
                w_v = (w_res[DW-1] != i_a[DW-1]);
            end
            OP_LSL: begin
                {w_c, w_res} = f_lsl(i_a, w_cnt);
                w_v = (w_res[DW-1] != i_a[DW-1]);
            end
            OP_ASR: {w_c, w_res} = f_asr(i_a, w_cnt);
            OP_MPY: begin
`ifdef ZIP_ALU_LODI_EN
                w_res = {i_b[DW/2-1:0], i_a[DW/2-1:0]};
`else
                w_mpy_op = 1'b1;
`endif
            end
            OP_LODILO: w_res = {i_a[DW-1:DW/2], i_b[DW/2-1:0]};
            OP_MPYHU,
            OP_MPYHS:  w_mpy_op = 1'b1;
            OP_BREV:   w_res = f_brev(i_b);
            OP_POPC:   w_res = f_popc(i_b);
            OP_ROL:    w_res = f_rol(i_a, i_b[RW-1:0]);
            default:   w_res = i_b;
        endcase
        if (w_mpy_op && !HAS_MPY)
            w_ill = 1'b1;
        w_f = '0;
        if (!w_ill) begin
            w_f[F_Z] = (w_res == '0);
            w_f[F_N] = w_res[DW-1];
            w_f[F_C] = w_c;
            w_f[F_V] = w_v;
        end
    end

    generate
        if (MPY_STAGES > 0) begin : g_mpy
            zip_alu_mpy #(
                .DW         (DW),
                .MPY_STAGES (MPY_STAGES)
            ) u_mpy (
                .i_clk    (i_clk),
                .i_rst_n  (i_rst_n),
                .i_start  (w_start_mpy),
                .i_clear  (i_clear),
                .i_signed (i_op == OP_MPYHS),
                .i_a      (i_a),
                .i_b      (i_b),
                .o_prod   (w_prod),
                .o_valid  (w_mpy_vld)
            );
        end else begin : g_no_mpy
            assign w_prod    = '0;
            assign w_mpy_vld = 1'b0;
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (w_start_mpy)
            r_mpy_hi <= (i_op != OP_MPY);
    end

    assign w_mpy_res = r_mpy_hi ? w_prod[2*DW-1:DW] : w_prod[DW-1:0];

    always_comb begin
        w_mf      = '0;
        w_mf[F_Z] = (w_mpy_res == '0);
        w_mf[F_N] = w_mpy_res[DW-1];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_start_mpy)
                r_cnt <= 3'(MPY_STAGES);
            else if (r_state == MPY)
                r_cnt <= r_cnt - 3'd1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start_mpy) w_next = MPY;
            MPY:     if (i_clear || r_cnt == 3'd1) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state == MPY);
        w_done = w_busy && (r_cnt == 3'd1) && w_mpy_vld && !i_clear;
    end

    assign o_busy = w_busy;

    // Result register: either a finishing multiply or a freshly accepted single-cycle op
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_c       <= '0;
            o_f       <= '0;
            o_valid   <= 1'b0;
            o_illegal <= 1'b0;
        end else begin
            o_valid   <= 1'b0;
            o_illegal <= 1'b0;
            if (w_done) begin
                o_c     <= w_mpy_res;
                o_f     <= w_mf;
                o_valid <= 1'b1;
            end else if (w_accept && !w_start_mpy) begin
                o_c       <= w_res;
                o_f       <= w_f;
                o_valid   <= 1'b1;
                o_illegal <= w_ill;
            end
        end
    end

endmodule

// File: tb/tb_zip_alu_ex.sv
// Scoreboard bench for zip_alu_ex: directed corner cases plus randomized ops vs a reference model.
module tb_zip_alu_ex;
    import zip_alu_pkg::*;

    localparam int DW         = 32;
    localparam int MPY_STAGES = 2;

    typedef struct {
        logic [31:0] c;
        logic [3:0]  f;
        logic        ill;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b1;
    logic        i_ce = 1'b0, i_valid = 1'b0, i_clear = 1'b0;
    logic [3:0]  i_op = 4'h0;
    logic [31:0] i_a = '0, i_b = '0;
    logic [31:0] o_c;
    logic [3:0]  o_f;
    logic        o_valid, o_busy, o_illegal;

    int   checks = 0, failures = 0, cyc = 0;
    exp_t exq[$];
    exp_t mon_e;

    zip_alu_ex #(.DW(DW), .MPY_STAGES(MPY_STAGES)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce(i_ce), .i_valid(i_valid), .i_clear(i_clear),
        .i_op(i_op), .i_a(i_a), .i_b(i_b), .o_c(o_c), .o_f(o_f),
        .o_valid(o_valid), .o_busy(o_busy), .o_illegal(o_illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic bit is_mpy(input logic [3:0] op);
`ifdef ZIP_ALU_LODI_EN
        return (op == 4'hA) || (op == 4'hB);
`else
        return (op == 4'h8) || (op == 4'hA) || (op == 4'hB);
`endif
    endfunction

    // Reference: plain arithmetic and bit-at-a-time shifting
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint r;
        logic [63:0] p;
        logic [31:0] x;
        bit cy, vv;
        int n;
        x = '0; cy = 0; vv = 0; e.ill = 1'b0; e.cyc = 0;
        n = (b > 32'd40) ? 40 : int'(b);
        case (op)
            4'h0: begin
                x = a - b; cy = (b > a);
                r = longint'($signed(a)) - longint'($signed(b));
                vv = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            4'h1: x = a & b;
            4'h2: begin
                x = a + b; cy = (longint'(a) + longint'(b)) > 64'sh0FFFFFFFF;
                r = longint'($signed(a)) + longint'($signed(b));
                vv = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            4'h3: x = a | b;
            4'h4: x = a ^ b;
            4'h5: begin x = a; repeat (n) begin cy = x[0];  x = x >> 1; end vv = (x[31] != a[31]); end
            4'h6: begin x = a; repeat (n) begin cy = x[31]; x = x << 1; end vv = (x[31] != a[31]); end
            4'h7: begin x = a; repeat (n) begin cy = x[0];  x = {x[31], x[31:1]}; end end
            4'h8: begin
`ifdef ZIP_ALU_LODI_EN
                x = {b[15:0], a[15:0]};
`else
                p = {32'h0, a} * {32'h0, b}; x = p[31:0];
`endif
            end
            4'h9: x = {a[31:16], b[15:0]};
            4'hA: begin p = {32'h0, a} * {32'h0, b}; x = p[63:32]; end
            4'hB: begin p = 64'(longint'($signed(a)) * longint'($signed(b))); x = p[63:32]; end
            4'hC: for (int k = 0; k < 32; k++) x[k] = b[31-k];
            4'hD: x = 32'($countones(b));
            4'hE: begin x = a; repeat (int'(b % 32)) x = {x[30:0], x[31]}; end
            default: x = b;
        endcase
        e.c = x;
        e.f = {vv, x[31], cy, (x == 32'h0)};
        return e;
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 9))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h7FFFFFFF;
            3: return 32'h80000000;
            4: return 32'hFFFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] pick_cnt();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'd31;
            3: return 32'd32;
            4: return 32'd33;
            5: return 32'd40;
            6: return 32'($urandom_range(0, 63));
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit use_k, input logic [31:0] kc, input logic [3:0] kf,
                         input bit rnd_ce, output int waited);
        exp_t e;
        bit done;
        done = 1'b0; waited = 0;
        @(negedge clk);
        i_op = op; i_a = a; i_b = b; i_valid = 1'b1;
        while (!done) begin
            i_ce = rnd_ce ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (i_ce && !o_busy) begin
                e = model(op, a, b);
                if (use_k) begin e.c = kc; e.f = kf; end
                e.cyc = cyc + 1 + (is_mpy(op) ? MPY_STAGES : 0);
                exq.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            if (!done) begin
                waited++;
                if (waited > 20) begin
                    checks++; failures++;
                    $display("FAIL accept_timeout op=%h busy=%b", op, o_busy);
                    done = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
        end
        #1;
        i_valid = 1'b0; i_ce = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && o_valid) begin
            checks++;
            if (exq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid c=%h f=%b cyc=%0d", o_c, o_f, cyc);
            end else begin
                mon_e = exq.pop_front();
                if (o_c !== mon_e.c || o_f !== mon_e.f || o_illegal !== mon_e.ill ||
                    o_busy !== 1'b0 || cyc != mon_e.cyc) begin
                    failures++;
                    $display("FAIL result got c=%h f=%b ill=%b busy=%b cyc=%0d exp c=%h f=%b ill=%b cyc=%0d",
                             o_c, o_f, o_illegal, o_busy, cyc, mon_e.c, mon_e.f, mon_e.ill, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [3:0]  op;
        logic [31:0] a, b;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_c", o_c, 32'h0);
        chk("rst_f", 32'(o_f), 32'h0);
        chk("rst_valid", 32'(o_valid), 32'h0);
        chk("rst_busy", 32'(o_busy), 32'h0);
        chk("rst_illegal", 32'(o_illegal), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        issue(OP_ADD, 32'h7FFFFFFF, 32'h1,        1, 32'h80000000, 4'b1100, 0, w);
        issue(OP_SUB, 32'd5,        32'd5,        1, 32'h0,        4'b0001, 0, w);
        issue(OP_SUB, 32'd0,        32'd1,        1, 32'hFFFFFFFF, 4'b0110, 0, w);
        issue(OP_LSR, 32'h80000001, 32'd32,       1, 32'h0,        4'b1011, 0, w);
        issue(OP_LSR, 32'h80000001, 32'd33,       1, 32'h0,        4'b1001, 0, w);
        issue(OP_ASR, 32'h80000000, 32'd40,       1, 32'hFFFFFFFF, 4'b0110, 0, w);
        issue(OP_LSL, 32'h00000003, 32'd32,       1, 32'h0,        4'b0011, 0, w);
        issue(OP_LSR, 32'h12345678, 32'd0,        1, 32'h12345678, 4'b0000, 0, w);
        issue(OP_ROL, 32'h80000001, 32'd33,       1, 32'h00000003, 4'b0000, 0, w);

        issue(OP_MPYHS, 32'hFFFFFFFF, 32'd2, 1, 32'hFFFFFFFF, 4'b0100, 0, w);
        chk("mpy_busy_c1", 32'(o_busy), 32'h1);
        @(posedge clk); #1;
        chk("mpy_busy_c2", 32'(o_busy), 32'h1);
        chk("mpy_novalid_c2", 32'(o_valid), 32'h0);
        @(posedge clk); #1;
        chk("mpy_busy_end", 32'(o_busy), 32'h0);
        chk("mpy_valid_c3", 32'(o_valid), 32'h1);

        issue(OP_MPYHU, 32'hFFFFFFFF, 32'd2, 1, 32'h00000001, 4'b0000, 0, w);
        issue(OP_ADD, 32'd3, 32'd4, 1, 32'd7, 4'b0000, 0, w);
        chk("held_add_wait", 32'(w), 32'd2);

        issue(OP_MPY, 32'h1234, 32'h5678, 0, 32'h0, 4'h0, 0, w);
        i_clear = 1'b1;
        chk("clr_busy_before", 32'(o_busy), 32'h1);
        void'(exq.pop_back());
        @(posedge clk); #1;
        i_clear = 1'b0;
        chk("clr_busy_after", 32'(o_busy), 32'h0);
        repeat (3) @(posedge clk);

        @(negedge clk);
        i_op = OP_MPY; i_a = 32'd9; i_b = 32'd9; i_valid = 1'b1; i_ce = 1'b1; i_clear = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0; i_ce = 1'b0; i_clear = 1'b0;
        chk("clr_accept_busy", 32'(o_busy), 32'h0);
        chk("clr_accept_valid", 32'(o_valid), 32'h0);
        repeat (3) @(posedge clk);

        issue(OP_ADD, 32'd1, 32'd1, 1, 32'd2, 4'b0000, 0, w);

        for (int k = 0; k < 300; k++) begin
            op = 4'($urandom_range(0, 15));
            a  = pick32();
            b  = (op == OP_LSR || op == OP_LSL || op == OP_ASR || op == OP_ROL) ? pick_cnt() : pick32();
            issue(op, a, b, 0, 32'h0, 4'h0, 1, w);
        end

        issue(OP_SUB, 32'd0, 32'd1, 1, 32'hFFFFFFFF, 4'b0110, 0, w);
        issue(OP_MPYHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h0, 4'h0, 0, w);
        @(posedge clk); #1;
        chk("rst_pre_busy", 32'(o_busy), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(o_busy), 32'h0);
        chk("rst_mid_valid", 32'(o_valid), 32'h0);
        chk("rst_mid_illegal", 32'(o_illegal), 32'h0);
        chk("rst_mid_c", o_c, 32'h0);
        chk("rst_mid_f", 32'(o_f), 32'h0);
        exq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);

        for (int k = 0; k < 10 && exq.size() != 0; k++) @(posedge clk);
        chk("scoreboard_drained", 32'(exq.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
